riscv_mem_arbiter: RTL and testbench

- Shares one single-port, fixed-latency unified memory between the core's instruction-fetch port and its data (load/store) port.
- Sits between the riscv core and the memory.
  - The core's inst_addr_o/inst_ce_o drive the IF request.
  - The core's data_addr_o/data_we_o/data_o drive the D request.
- Returns read data with a one-cycle ack pulse per port.
- Drives stall_o, which freezes the pipeline (PC, IF/ID, and the rest) while either port is waiting.

---
 rtl/riscv_mem_arbiter_pkg.sv | 24 ++
 rtl/riscv_mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_riscv_mem_arbiter.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_mem_arbiter_pkg.sv
// Shared types and helpers for the instruction/data memory arbiter.
package riscv_mem_arbiter_pkg;

    // Width of the memory latency down-counter (covers MEM_LAT 1..15)
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY_IF = 2'd1,
        ARB_BUSY_D  = 2'd2,
        ARB_RESP    = 2'd3
    } arb_state_t;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } arb_port_t;

    // Counter value loaded on grant so that BUSY lasts exactly `lat` cycles
    function automatic logic [CNT_W-1:0] lat_load(input int unsigned lat);
        return CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/riscv_mem_arbiter.sv
// Arbitrates one single-port, fixed-latency unified memory between the
// core's instruction-fetch port and its load/store port. Data requests win
// from IDLE; the RESP cycle hands the memory to the other port if it waits.
module riscv_mem_arbiter
    import riscv_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,

    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_ack_o,

    output logic              mem_ce_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,

    output logic              stall_o
);

    localparam logic [CNT_W-1:0] LAT_LOAD = lat_load(MEM_LAT);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    arb_port_t         r_owner;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;

    logic              w_busy;
    logic              w_done;
    logic              w_grant_if;
    logic              w_grant_d;

    assign w_busy = (r_state == ARB_BUSY_IF) || (r_state == ARB_BUSY_D);
    assign w_done = w_busy && (r_cnt == '0);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and grant decision
    always_comb begin
        w_state_nxt = r_state;
        w_grant_if  = 1'b0;
        w_grant_d   = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (d_req_i) begin
                    w_grant_d = 1'b1;
                end else if (if_req_i) begin
                    w_grant_if = 1'b1;
                end
            end
            ARB_BUSY_IF, ARB_BUSY_D: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ARB_RESP;
                end
            end
            ARB_RESP: begin
                // The owner's own request is ignored: the core consumes this ack
                if ((r_owner == PORT_IF) && d_req_i) begin
                    w_grant_d = 1'b1;
                end else if ((r_owner == PORT_D) && if_req_i) begin
                    w_grant_if = 1'b1;
                end else begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
        if (w_grant_d) begin
            w_state_nxt = ARB_BUSY_D;
        end else if (w_grant_if) begin
            w_state_nxt = ARB_BUSY_IF;
        end
    end

    // Latch the granted request, track the owner and count down the latency
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner <= PORT_IF;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
        end else if (w_grant_d) begin
            r_owner <= PORT_D;
            r_cnt   <= LAT_LOAD;
            r_addr  <= d_addr_i;
            r_we    <= d_we_i;
            r_wdata <= d_wdata_i;
        end else if (w_grant_if) begin
            r_owner <= PORT_IF;
            r_cnt   <= LAT_LOAD;
            r_addr  <= if_addr_i;
            r_we    <= 1'b0;
            r_wdata <= '0;
        end else if (w_busy && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Capture read data in the last memory cycle; stores keep the old load data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else if (w_done) begin
            if (r_state == ARB_BUSY_IF) begin
                r_if_rdata <= mem_rdata_i;
            end else if (!r_we) begin
                r_d_rdata <= mem_rdata_i;
            end
        end
    end

    // Memory bus and acks decoded from state, so reset clears them at once
    always_comb begin
        mem_ce_o    = w_busy;
        mem_we_o    = w_busy && r_we;
        mem_addr_o  = w_busy ? r_addr  : '0;
        mem_wdata_o = w_busy ? r_wdata : '0;
        if_ack_o    = (r_state == ARB_RESP) && (r_owner == PORT_IF);
        d_ack_o     = (r_state == ARB_RESP) && (r_owner == PORT_D);
    end

    // Pipeline stall while any port waits; drops in the ack cycle
    always_comb begin
        stall_o = (if_req_i && !if_ack_o) || (d_req_i && !d_ack_o);
    end

    assign if_rdata_o = r_if_rdata;
    assign d_rdata_o  = r_d_rdata;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Scoreboard bench for riscv_mem_arbiter: directed stimulus pushes expected
// memory beats, acks and stall values; negedge monitors pop and compare.
module tb_riscv_mem_arbiter;

    typedef struct { int cyc; logic [31:0] data; } ack_t;
    typedef struct { int cyc; logic [31:0] addr; logic we; logic [31:0] wdata; } beat_t;
    typedef struct { int cyc; logic val; } stl_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   tot = 0;
    int   bad = 0;

    // Instance A: MEM_LAT = 2
    logic        if_req_i = 0, d_req_i = 0, d_we_i = 0;
    logic [31:0] if_addr_i = 0, d_addr_i = 0, d_wdata_i = 0;
    logic [31:0] if_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic        if_ack_o, d_ack_o, mem_ce_o, mem_we_o, stall_o;

    // Instance B: MEM_LAT = 1
    logic        b_if_req = 0, b_d_req = 0, b_d_we = 0;
    logic [31:0] b_if_addr = 0, b_d_addr = 0, b_d_wdata = 0;
    logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic        b_if_ack, b_d_ack, b_mem_ce, b_mem_we, b_stall;

    ack_t  if_q[$], d_q[$], bif_q[$];
    beat_t beat_q[$], bbeat_q[$];
    stl_t  stl_q[$];

    int a_beat = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    riscv_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) u_dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_rdata_o(d_rdata_o), .d_ack_o(d_ack_o),
        .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .stall_o(stall_o)
    );

    riscv_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut_lat1 (
        .clk(clk), .rst(rst),
        .if_req_i(b_if_req), .if_addr_i(b_if_addr), .if_rdata_o(b_if_rdata), .if_ack_o(b_if_ack),
        .d_req_i(b_d_req), .d_we_i(b_d_we), .d_addr_i(b_d_addr), .d_wdata_i(b_d_wdata),
        .d_rdata_o(b_d_rdata), .d_ack_o(b_d_ack),
        .mem_ce_o(b_mem_ce), .mem_we_o(b_mem_we), .mem_addr_o(b_mem_addr),
        .mem_wdata_o(b_mem_wdata), .mem_rdata_i(b_mem_rdata), .stall_o(b_stall)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h0050_0093;
            32'h0000_0104: return 32'h00A0_0113;
            32'h0000_0200: return 32'h0000_0013;
            32'h0000_2004: return 32'h1234_5678;
            default:       return 32'h0BAD_F00D;
        endcase
    endfunction

    // Memory models: read data valid only in the MEM_LAT-th cycle of an access
    always @(posedge clk) a_beat <= mem_ce_o ? a_beat + 1 : 0;
    assign mem_rdata_i = (mem_ce_o && a_beat == 1) ? mem_word(mem_addr_o) : 32'hBAD0_BAD0;
    assign b_mem_rdata = b_mem_ce ? mem_word(b_mem_addr) : 32'hBAD0_BAD0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tot++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_beat(input int c, input logic [31:0] a, input logic we, input logic [31:0] wd);
        beat_t b;
        b.cyc = c; b.addr = a; b.we = we; b.wdata = wd;
        beat_q.push_back(b);
    endtask

    task automatic exp_stall(input int c0, input int c1, input logic v);
        stl_t s;
        for (int c = c0; c <= c1; c++) begin
            s.cyc = c; s.val = v;
            stl_q.push_back(s);
        end
    endtask

    task automatic exp_ack(input int port, input int c, input logic [31:0] dat);
        ack_t e;
        e.cyc = c; e.data = dat;
        case (port)
            0: if_q.push_back(e);
            1: d_q.push_back(e);
            default: bif_q.push_back(e);
        endcase
    endtask

    // Monitor for instance A
    always @(negedge clk) begin
        ack_t  e;
        beat_t b;
        stl_t  s;
        if (if_ack_o) begin
            if (if_q.size() == 0) chk("if_ack_unexpected", if_ack_o, 0);
            else begin
                e = if_q.pop_front();
                chk("if_ack_cycle", cyc, e.cyc);
                chk("if_rdata", if_rdata_o, e.data);
            end
        end
        if (d_ack_o) begin
            if (d_q.size() == 0) chk("d_ack_unexpected", d_ack_o, 0);
            else begin
                e = d_q.pop_front();
                chk("d_ack_cycle", cyc, e.cyc);
                chk("d_rdata", d_rdata_o, e.data);
            end
        end
        if (mem_ce_o) begin
            if (beat_q.size() == 0) chk("mem_ce_unexpected", mem_ce_o, 0);
            else begin
                b = beat_q.pop_front();
                chk("mem_beat_cycle", cyc, b.cyc);
                chk("mem_addr", mem_addr_o, b.addr);
                chk("mem_we", mem_we_o, b.we);
                if (b.we) chk("mem_wdata", mem_wdata_o, b.wdata);
            end
        end
        if (stl_q.size() != 0 && stl_q[0].cyc == cyc) begin
            s = stl_q.pop_front();
            chk("stall", stall_o, s.val);
        end
    end

    // Monitor for instance B
    always @(negedge clk) begin
        ack_t  e;
        beat_t b;
        if (b_if_ack) begin
            if (bif_q.size() == 0) chk("lat1_if_ack_unexpected", b_if_ack, 0);
            else begin
                e = bif_q.pop_front();
                chk("lat1_if_ack_cycle", cyc, e.cyc);
                chk("lat1_if_rdata", b_if_rdata, e.data);
            end
        end
        if (b_d_ack) chk("lat1_d_ack_unexpected", b_d_ack, 0);
        if (b_mem_ce) begin
            if (bbeat_q.size() == 0) chk("lat1_mem_ce_unexpected", b_mem_ce, 0);
            else begin
                b = bbeat_q.pop_front();
                chk("lat1_beat_cycle", cyc, b.cyc);
                chk("lat1_mem_addr", b_mem_addr, b.addr);
                chk("lat1_mem_we", b_mem_we, b.we);
            end
        end
    end

    initial begin
        int    t0;
        int    t1;
        beat_t bb;

        // Reset state
        tick(2);
        chk("rst_mem_ce", mem_ce_o, 0);
        chk("rst_mem_we", mem_we_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_mem_wdata", mem_wdata_o, 0);
        chk("rst_if_ack", if_ack_o, 0);
        chk("rst_d_ack", d_ack_o, 0);
        chk("rst_if_rdata", if_rdata_o, 0);
        chk("rst_d_rdata", d_rdata_o, 0);
        chk("rst_stall", stall_o, 0);
        rst = 1'b1;
        tick(2);

        // Isolated fetch
        t0 = cyc;
        if_req_i = 1; if_addr_i = 32'h100;
        exp_beat(t0 + 1, 32'h100, 0, 0);
        exp_beat(t0 + 2, 32'h100, 0, 0);
        exp_ack(0, t0 + 3, 32'h0050_0093);
        exp_stall(t0, t0 + 2, 1);
        exp_stall(t0 + 3, t0 + 4, 0);
        tick(4); if_req_i = 0; tick(2);

        // Simultaneous load and fetch: data first, fetch handed over in RESP
        t0 = cyc;
        d_req_i = 1; d_we_i = 0; d_addr_i = 32'h2004;
        if_req_i = 1; if_addr_i = 32'h200;
        exp_beat(t0 + 1, 32'h2004, 0, 0);
        exp_beat(t0 + 2, 32'h2004, 0, 0);
        exp_ack(1, t0 + 3, 32'h1234_5678);
        exp_beat(t0 + 4, 32'h200, 0, 0);
        exp_beat(t0 + 5, 32'h200, 0, 0);
        exp_ack(0, t0 + 6, 32'h0000_0013);
        exp_stall(t0, t0 + 5, 1);
        exp_stall(t0 + 6, t0 + 6, 0);
        tick(4); d_req_i = 0; tick(3); if_req_i = 0; tick(2);

        // Store: load data register must keep the previous load value
        t0 = cyc;
        d_req_i = 1; d_we_i = 1; d_addr_i = 32'h3000; d_wdata_i = 32'hDEAD_BEEF;
        exp_beat(t0 + 1, 32'h3000, 1, 32'hDEAD_BEEF);
        exp_beat(t0 + 2, 32'h3000, 1, 32'hDEAD_BEEF);
        exp_ack(1, t0 + 3, 32'h1234_5678);
        tick(4); d_req_i = 0; d_we_i = 0; d_wdata_i = 0; tick(2);

        // Back-to-back fetches: second granted from IDLE
        t0 = cyc;
        if_req_i = 1; if_addr_i = 32'h100;
        exp_beat(t0 + 1, 32'h100, 0, 0);
        exp_beat(t0 + 2, 32'h100, 0, 0);
        exp_ack(0, t0 + 3, 32'h0050_0093);
        exp_beat(t0 + 5, 32'h104, 0, 0);
        exp_beat(t0 + 6, 32'h104, 0, 0);
        exp_ack(0, t0 + 7, 32'h00A0_0113);
        exp_stall(t0, t0 + 2, 1);
        exp_stall(t0 + 3, t0 + 3, 0);
        exp_stall(t0 + 4, t0 + 6, 1);
        exp_stall(t0 + 7, t0 + 7, 0);
        tick(4); if_addr_i = 32'h104; tick(4); if_req_i = 0; tick(2);

        // Asynchronous reset in the first BUSY_D cycle, then full restart
        t0 = cyc;
        d_req_i = 1; d_we_i = 0; d_addr_i = 32'h2004;
        tick(1);
        rst = 1'b0;
        #1;
        chk("arst_mem_ce", mem_ce_o, 0);
        chk("arst_mem_we", mem_we_o, 0);
        chk("arst_mem_addr", mem_addr_o, 0);
        chk("arst_mem_wdata", mem_wdata_o, 0);
        chk("arst_d_ack", d_ack_o, 0);
        chk("arst_if_ack", if_ack_o, 0);
        chk("arst_d_rdata", d_rdata_o, 0);
        chk("arst_if_rdata", if_rdata_o, 0);
        tick(2);
        rst = 1'b1;
        t0 = cyc;
        exp_beat(t0 + 1, 32'h2004, 0, 0);
        exp_beat(t0 + 2, 32'h2004, 0, 0);
        exp_ack(1, t0 + 3, 32'h1234_5678);
        tick(4); d_req_i = 0; tick(2);

        // MEM_LAT = 1: fetch flushed mid-access still acks, next grant normal
        t0 = cyc;
        b_if_req = 1; b_if_addr = 32'h100;
        bb.cyc = t0 + 1; bb.addr = 32'h100; bb.we = 0; bb.wdata = 0;
        bbeat_q.push_back(bb);
        exp_ack(2, t0 + 2, 32'h0050_0093);
        tick(1); b_if_req = 0; tick(2);
        t1 = cyc;
        b_if_req = 1; b_if_addr = 32'h104;
        bb.cyc = t1 + 1; bb.addr = 32'h104;
        bbeat_q.push_back(bb);
        exp_ack(2, t1 + 2, 32'h00A0_0113);
        tick(3); b_if_req = 0; tick(3);

        // Every expected event must have been observed
        chk("if_acks_missing", if_q.size(), 0);
        chk("d_acks_missing", d_q.size(), 0);
        chk("mem_beats_missing", beat_q.size(), 0);
        chk("stall_checks_missing", stl_q.size(), 0);
        chk("lat1_acks_missing", bif_q.size(), 0);
        chk("lat1_beats_missing", bbeat_q.size(), 0);

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
